// File: rtl/sfifo_drain_stage.sv
// Drains a 16-entry circular FIFO into a 2-slot output/skid buffer, tagging each entry with its read pointer.
// Optional macro SFIFO_DRAIN_STALL_CNT_EN adds o_stall_cnt, a saturating count of stalled output cycles.
module sfifo_drain_stage #(
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_flush,
  input  logic [DW-1:0] i_fifo_data,
  input  logic          i_fifo_empty,
  input  logic [4:0]    i_fifo_rptr,
  output logic          o_fifo_rd,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic [4:0]    o_tag,
  input  logic          i_ready,
  output logic [1:0]    o_occupancy
`ifdef SFIFO_DRAIN_STALL_CNT_EN
  ,
  output logic [31:0]   o_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    OCC0 = 2'd0,
    OCC1 = 2'd1,
    OCC2 = 2'd2
  } occ_e;

  occ_e          occ, occ_nxt;
  logic [DW-1:0] out_data, skid_data;
  logic [4:0]    out_tag, skid_tag;
  logic          push, pop;
  logic          ld_out_new, ld_out_skid, ld_skid;

  // Pop decision uses registered occupancy only, so i_ready never reaches o_fifo_rd.
  assign push        = ~i_fifo_empty & (occ != OCC2) & ~i_flush & ~i_reset;
  assign o_fifo_rd   = push;
  assign o_valid     = (occ != OCC0) & ~i_flush;
  assign pop         = o_valid & i_ready;
  assign o_data      = out_data;
  assign o_tag       = out_tag;
  assign o_occupancy = occ;

  always_comb begin
    occ_nxt     = occ;
    ld_out_new  = 1'b0;
    ld_out_skid = 1'b0;
    ld_skid     = 1'b0;
    case (occ)
      OCC0: begin
        if (push) begin
          ld_out_new = 1'b1;
          occ_nxt    = OCC1;
        end
      end
      OCC1: begin
        if (push && pop) begin
          ld_out_new = 1'b1;
        end else if (push) begin
          ld_skid = 1'b1;
          occ_nxt = OCC2;
        end else if (pop) begin
          occ_nxt = OCC0;
        end
      end
      OCC2: begin
        if (pop) begin
          ld_out_skid = 1'b1;
          occ_nxt     = OCC1;
        end
      end
      default: occ_nxt = OCC0;
    endcase
    // Flush forces push and pop low, so only the occupancy needs clearing.
    if (i_flush) occ_nxt = OCC0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) occ <= OCC0;
    else         occ <= occ_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      out_data  <= '0;
      out_tag   <= '0;
      skid_data <= '0;
      skid_tag  <= '0;
    end else begin
      if (ld_out_new) begin
        out_data <= i_fifo_data;
        out_tag  <= i_fifo_rptr;
      end else if (ld_out_skid) begin
        out_data <= skid_data;
        out_tag  <= skid_tag;
      end
      if (ld_skid) begin
        skid_data <= i_fifo_data;
        skid_tag  <= i_fifo_rptr;
      end
    end
  end

`ifdef SFIFO_DRAIN_STALL_CNT_EN
  always_ff @(posedge i_clk) begin
    if (i_reset)                                      o_stall_cnt <= '0;
    else if (o_valid && !i_ready && o_stall_cnt != '1) o_stall_cnt <= o_stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_sfifo_drain_stage.sv
// Bench for sfifo_drain_stage: behavioural FIFO upstream, queue-based reference model, table and random tests.
module tb_sfifo_drain_stage;
  localparam int DW = 8;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_flush = 1'b0;
  logic          i_ready = 1'b0;
  logic [DW-1:0] i_fifo_data;
  logic          i_fifo_empty;
  logic [4:0]    i_fifo_rptr;
  logic          o_fifo_rd, o_valid;
  logic [DW-1:0] o_data;
  logic [4:0]    o_tag;
  logic [1:0]    o_occupancy;
`ifdef SFIFO_DRAIN_STALL_CNT_EN
  logic [31:0]   o_stall_cnt;
`endif

  // Upstream FIFO model: combinational head read, wrap-bit pointers.
  logic [DW-1:0] fifo_mem [16];
  logic [4:0]    wptr = '0;
  logic [4:0]    rptr = '0;
  assign i_fifo_data  = fifo_mem[rptr[3:0]];
  assign i_fifo_empty = (wptr == rptr);
  assign i_fifo_rptr  = rptr;

  sfifo_drain_stage #(.DW(DW)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_flush      (i_flush),
    .i_fifo_data  (i_fifo_data),
    .i_fifo_empty (i_fifo_empty),
    .i_fifo_rptr  (i_fifo_rptr),
    .o_fifo_rd    (o_fifo_rd),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .o_tag        (o_tag),
    .i_ready      (i_ready),
    .o_occupancy  (o_occupancy)
`ifdef SFIFO_DRAIN_STALL_CNT_EN
    ,
    .o_stall_cnt  (o_stall_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [4:0]    tag;
  } ent_t;

  typedef struct {
    bit         rdy;
    bit         exp_rd;
    bit         exp_valid;
    logic [1:0] exp_occ;
    logic [7:0] exp_data;
  } vec_t;

  ent_t        sb[$];
  logic [4:0]  got_tags[$];
  int          checks = 0;
  int          failures = 0;
  int          rd_cnt = 0;
  int          vld_cnt = 0;
  bit          rst_prev = 1'b1;
  logic [31:0] stall_model = '0;
  vec_t        bp[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fifo_write(input logic [DW-1:0] d);
    if (5'(wptr - rptr) < 5'd16) begin
      fifo_mem[wptr[3:0]] = d;
      wptr = wptr + 5'd1;
    end
  endtask

  // One clock cycle: drive at negedge, check against model, advance model and FIFO.
  task automatic step(input bit rst, input bit fl, input bit rdy);
    bit   exp_rd, exp_valid, rd_act;
    ent_t e;
    i_reset = rst;
    i_flush = fl;
    i_ready = rdy;
    #1;
    exp_rd    = (wptr != rptr) && (sb.size() < 2) && !fl && !rst;
    exp_valid = (sb.size() != 0) && !fl;
    chk("fifo_rd", 32'(o_fifo_rd), 32'(exp_rd));
    chk("valid", 32'(o_valid), 32'(exp_valid));
    chk("occupancy", 32'(o_occupancy), 32'(sb.size()));
    if (exp_valid && o_valid) begin
      chk("data", 32'(o_data), 32'(sb[0].data));
      chk("tag", 32'(o_tag), 32'(sb[0].tag));
    end
    if (rst_prev) begin
      chk("reset_data", 32'(o_data), 32'd0);
      chk("reset_tag", 32'(o_tag), 32'd0);
    end
`ifdef SFIFO_DRAIN_STALL_CNT_EN
    chk("stall_cnt", o_stall_cnt, stall_model);
`endif
    rd_act = o_fifo_rd;
    if (o_fifo_rd) rd_cnt++;
    if (o_valid) vld_cnt++;
    if (o_valid && rdy && !rst) got_tags.push_back(o_tag);
    if (rst) begin
      sb.delete();
      stall_model = '0;
    end else begin
      if (exp_valid && !rdy && stall_model != 32'hFFFF_FFFF) stall_model++;
      if (fl) sb.delete();
      else begin
        if (exp_valid && rdy) void'(sb.pop_front());
        if (exp_rd) begin
          e.data = fifo_mem[rptr[3:0]];
          e.tag  = rptr;
          sb.push_back(e);
        end
      end
    end
    rst_prev = rst;
    @(posedge i_clk);
    @(negedge i_clk);
    if (rd_act) rptr = rptr + 5'd1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0 && wptr == rptr) break;
      step(1'b0, 1'b0, 1'b1);
    end
    chk("drained", 32'(sb.size()) + 32'(5'(wptr - rptr)), 32'd0);
  endtask

  initial begin
    bp[0] = '{1'b0, 1'b1, 1'b0, 2'd0, 8'h00};
    bp[1] = '{1'b0, 1'b1, 1'b1, 2'd1, 8'hA0};
    bp[2] = '{1'b0, 1'b0, 1'b1, 2'd2, 8'hA0};
    bp[3] = '{1'b0, 1'b0, 1'b1, 2'd2, 8'hA0};
    bp[4] = '{1'b0, 1'b0, 1'b1, 2'd2, 8'hA0};
    bp[5] = '{1'b1, 1'b0, 1'b1, 2'd2, 8'hA0};
    bp[6] = '{1'b1, 1'b1, 1'b1, 2'd1, 8'hA1};
    bp[7] = '{1'b1, 1'b1, 1'b1, 2'd1, 8'hA2};
    bp[8] = '{1'b1, 1'b0, 1'b1, 2'd1, 8'hA3};
    bp[9] = '{1'b1, 1'b0, 1'b0, 2'd0, 8'h00};

    for (int i = 0; i < 16; i++) fifo_mem[i] = '0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);

    // Reset state
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Streaming: 6 entries at rptr 0..5, ready held high
    for (int i = 0; i < 6; i++) fifo_write(8'(8'h10 + i));
    rd_cnt = 0; vld_cnt = 0; got_tags.delete();
    repeat (9) step(1'b0, 1'b0, 1'b1);
    chk("stream_rd_cycles", 32'(rd_cnt), 32'd6);
    chk("stream_valid_cycles", 32'(vld_cnt), 32'd6);
    chk("stream_count", 32'(got_tags.size()), 32'd6);
    for (int i = 0; i < 6 && i < got_tags.size(); i++) chk("stream_tag", 32'(got_tags[i]), 32'(i));

    // Backpressure table
    drain();
    for (int i = 0; i < 4; i++) fifo_write(8'(8'hA0 + i));
    for (int i = 0; i < 10; i++) begin
      i_reset = 1'b0; i_flush = 1'b0; i_ready = bp[i].rdy;
      #1;
      chk("bp_rd", 32'(o_fifo_rd), 32'(bp[i].exp_rd));
      chk("bp_valid", 32'(o_valid), 32'(bp[i].exp_valid));
      chk("bp_occ", 32'(o_occupancy), 32'(bp[i].exp_occ));
      if (bp[i].exp_valid) chk("bp_data", 32'(o_data), 32'(bp[i].exp_data));
      step(1'b0, 1'b0, bp[i].rdy);
    end

    // Wrap tag: pointers moved to 30
    drain();
    rptr = 5'd30; wptr = 5'd30;
    for (int i = 0; i < 4; i++) fifo_write(8'(8'h50 + i));
    got_tags.delete();
    repeat (6) step(1'b0, 1'b0, 1'b1);
    chk("wrap_count", 32'(got_tags.size()), 32'd4);
    if (got_tags.size() == 4) begin
      chk("wrap_tag0", 32'(got_tags[0]), 32'd30);
      chk("wrap_tag1", 32'(got_tags[1]), 32'd31);
      chk("wrap_tag2", 32'(got_tags[2]), 32'd0);
      chk("wrap_tag3", 32'(got_tags[3]), 32'd1);
    end

    // Flush from occ=2 with ready high
    drain();
    for (int i = 0; i < 3; i++) fifo_write(8'(8'hC0 + i));
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("pre_flush_occ", 32'(o_occupancy), 32'd2);
    step(1'b0, 1'b1, 1'b1);
    #1;
    chk("post_flush_occ", 32'(o_occupancy), 32'd0);
    chk("post_flush_valid", 32'(o_valid), 32'd0);
    got_tags.delete();
    drain();
    chk("post_flush_delivered", 32'(got_tags.size()), 32'd1);

    // Reset while occ=1 and push active
    for (int i = 0; i < 4; i++) fifo_write(8'(8'hE0 + i));
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    drain();

`ifdef SFIFO_DRAIN_STALL_CNT_EN
    // Stall counter: 7 stalls, flush, 3 stalls
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) fifo_write(8'(8'h70 + i));
    step(1'b0, 1'b0, 1'b0);
    repeat (7) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    chk("stall_total", o_stall_cnt, 32'd10);
    drain();
`endif

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) != 0) fifo_write(8'($urandom));
      step($urandom_range(0, 199) == 0, $urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sfifo_drain_stage.md
Name: sfifo_drain_stage

Overview:
- Downstream consumer of the 16-entry circular-buffer FIFO (DW-wide, 5-bit wrap-bit pointers, combinational read data at read pointer).
- Pops entries into a 2-entry output/skid buffer and presents them on a valid/ready interface to the next pipeline stage.
- Tags each entry with the FIFO read pointer it was popped from.
- Supports a pipeline flush.
- i_ready has no combinational path to o_fifo_rd.

Parameters:
- DW, 8, data width; must match the upstream FIFO.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_flush  in  1  pipeline flush; discards buffered entries
- i_fifo_data  in  DW  FIFO combinational read data
- i_fifo_empty  in  1  FIFO empty flag
- i_fifo_rptr  in  5  FIFO read pointer, including wrap bit
- o_fifo_rd  out  1  FIFO pop request
- o_valid  out  1  output entry valid
- o_data  out  DW  output entry data
- o_tag  out  5  FIFO pointer the output entry was read from
- i_ready  in  1  downstream accepts the entry
- o_occupancy  out  2  buffered entries, 0..2

Behaviour:
- State: occ register, values 0/1/2. Two slots:
  - OUT slot: oldest entry; drives o_data/o_tag.
  - SKID slot: second entry.
- o_fifo_rd = ~i_fifo_empty & (occ != 2) & ~i_flush & ~i_reset. Registered-state only.
- push = o_fifo_rd. On push, {i_fifo_data, i_fifo_rptr} is captured at the same clock edge the FIFO pops.
- o_valid = (occ != 0) & ~i_flush.
- pop = o_valid & i_ready.
- Latency: entry at FIFO head in cycle N with occ < 2 appears on o_valid in cycle N+1.
- Transitions (non-flush, non-reset):
  - occ0: push -> OUT <= new, occ1.
  - occ1:
    - push & pop -> OUT <= new, occ1.
    - push only -> SKID <= new, occ2.
    - pop only -> occ0.
    - neither -> hold.
  - occ2:
    - pop -> OUT <= SKID, occ1. No push is possible in occ2.
    - else hold.
- Order: entries leave in FIFO pop order. Tags increase by 1 modulo 32 between consecutive entries, barring flush.
- Stability: while o_valid & ~i_ready, o_data and o_tag hold constant.
- Full throughput: one entry per cycle sustained when FIFO non-empty and i_ready held high (occ stays 1).
- Backpressure: with i_ready low, at most 2 entries are popped, then o_fifo_rd drops.
  - Once occ reaches 2, o_fifo_rd stays low for at least the next cycle even if i_ready rises.
- Flush:
  - In the flush cycle, o_fifo_rd = 0 and o_valid = 0, so no handshake occurs.
  - Next cycle: occ = 0, o_valid = 0. Slot contents are don't-care but unchanged.
  - The FIFO itself is not flushed by this block.
- Reset: occ = 0, OUT/SKID data and tags = 0, o_valid = 0, o_fifo_rd = 0, o_occupancy = 0.
  - Reset mid-stream discards both slots.
  - Reset has priority over flush and push.
- o_occupancy = occ.
- FIFO empty while occ > 0: remaining entries drain normally, with no spurious push.

Optional Feature:
- Macro: SFIFO_DRAIN_STALL_CNT_EN.
- Defined:
  - Adds port o_stall_cnt, out, 32 bits.
  - Increments every cycle o_valid & ~i_ready.
  - Saturates at 32'hFFFF_FFFF.
  - Reset to 0 by i_reset; not cleared by i_flush.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Streaming:
  - Stimulus: reset, FIFO preloaded with 0x10..0x15 at rptr 0..5, i_ready=1 constant.
  - Response: o_valid high cycles 1..6 after first o_fifo_rd; o_data 0x10..0x15 with o_tag 0..5; o_fifo_rd high 6 consecutive cycles.
- Backpressure:
  - Stimulus: 4 entries 0xA0..0xA3, i_ready=0 for 5 cycles, then 1.
  - Response: exactly 2 pops; o_occupancy=2; o_data=0xA0 stable during stall; o_fifo_rd=0 when occ=2; all four then delivered in order with no loss or duplication.
- Wrap tag:
  - Stimulus: FIFO rptr advanced to 30, then 4 entries streamed.
  - Response: o_tag sequence 30, 31, 0, 1.
- Flush:
  - Stimulus: occ=2, i_flush pulsed 1 cycle with i_ready=1.
  - Response: no handshake in flush cycle; o_valid=0 and o_occupancy=0 next cycle; o_fifo_rd=0 during flush; next FIFO entry delivered afterwards with its correct tag.
- Reset mid-operation:
  - Stimulus: i_reset asserted while occ=1 and push active.
  - Response: next cycle o_valid=0, o_data=0, o_tag=0, o_occupancy=0.
- Stall counter (SFIFO_DRAIN_STALL_CNT_EN defined):
  - Stimulus: 7 cycles of o_valid & ~i_ready, flush, 3 more stall cycles.
  - Response: o_stall_cnt=10.
